// File: rtl/rally_judge_pkg.sv
// Shared judge state and player types plus court geometry, also used by the
// physics and render blocks.
package rally_judge_pkg;

    typedef enum logic [2:0] {
        WAIT_SERVE,
        RALLY,
        AWARD,
        GAP,
        GAME_OVER
    } judge_state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    localparam logic [11:0] NET_X       = 12'd320;
    localparam logic [11:0] GROUND_Y    = 12'd440;
    localparam logic [11:0] COURT_LEFT  = 12'd40;
    localparam logic [11:0] COURT_RIGHT = 12'd600;

    function automatic logic out_of_bounds(input logic [11:0] x);
        return (x < COURT_LEFT) || (x > COURT_RIGHT);
    endfunction

    // The net column itself belongs to player2's half.
    function automatic player_t landing_winner(input logic [11:0] x);
        return (x < NET_X) ? P2 : P1;
    endfunction

endpackage

// File: rtl/rally_judge_if.sv
// Point-award handshake between the rally judge (master) and the score
// controller (slave).
interface rally_judge_if;

    logic player1_add_score;
    logic player2_add_score;
    logic player1_win;
    logic player2_win;

    modport master (
        output player1_add_score,
        output player2_add_score,
        input  player1_win,
        input  player2_win
    );

    modport slave (
        input  player1_add_score,
        input  player2_add_score,
        output player1_win,
        output player2_win
    );

endinterface

// File: rtl/rally_judge.sv
// Rally judge: serves, watches the shuttle, and awards points through the
// score handshake. Optional rally timeout enabled by defining RALLY_TIMEOUT_EN.
module rally_judge
    import rally_judge_pkg::*;
#(
    parameter int unsigned AWARD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
`ifdef RALLY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_FRAMES = 1800
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          serve_btn,
    input  logic          ball_valid,
    input  logic [11:0]   ball_x,
    input  logic [11:0]   ball_y,
    input  logic          hit_p1,
    input  logic          hit_p2,
    rally_judge_if.master score,
    output logic          serve_start,
    output logic          server,
    output logic          rally_active
);

    localparam int unsigned HOLD_MAX = (AWARD_CYCLES > GAP_CYCLES) ? AWARD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] AWARD_LOAD = CNT_W'(AWARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    judge_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    player_t          last_hitter;
    player_t          server_q;
    logic             add_p1;
    logic             add_p2;

    logic             ball_out;
    logic             ball_landed;
    logic             decide;
    player_t          winner;

`ifdef RALLY_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_FRAMES - 1);
    logic [11:0] frame_cnt;
`endif

    assign score.player1_add_score = add_p1;
    assign score.player2_add_score = add_p2;
    assign server                  = server_q;

    // Out-of-bounds outranks landing when a sample is both.
    always_comb begin
        ball_out    = out_of_bounds(ball_x);
        ball_landed = (ball_y >= GROUND_Y);
        decide      = ball_valid && (ball_out || ball_landed);
        winner      = ball_out ? player_t'(~last_hitter) : landing_winner(ball_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_SERVE;
            cnt          <= '0;
            btn_q        <= 1'b0;
            last_hitter  <= P1;
            server_q     <= P1;
            add_p1       <= 1'b0;
            add_p2       <= 1'b0;
            serve_start  <= 1'b0;
            rally_active <= 1'b0;
`ifdef RALLY_TIMEOUT_EN
            frame_cnt    <= '0;
`endif
        end else begin
            btn_q       <= serve_btn;
            serve_start <= 1'b0;
            if (score.player1_win || score.player2_win) begin
                state        <= GAME_OVER;
                add_p1       <= 1'b0;
                add_p2       <= 1'b0;
                rally_active <= 1'b0;
                server_q     <= P1;
            end else begin
                unique case (state)
                    WAIT_SERVE: begin
                        if (serve_btn && !btn_q) begin
                            serve_start  <= 1'b1;
                            rally_active <= 1'b1;
                            last_hitter  <= server_q;
                            state        <= RALLY;
`ifdef RALLY_TIMEOUT_EN
                            frame_cnt    <= '0;
`endif
                        end
                    end
                    RALLY: begin
                        if (decide) begin
                            state        <= AWARD;
                            rally_active <= 1'b0;
                            server_q     <= winner;
                            add_p1       <= (winner == P1);
                            add_p2       <= (winner == P2);
                            cnt          <= AWARD_LOAD;
`ifdef RALLY_TIMEOUT_EN
                        end else if (ball_valid && (frame_cnt == TIMEOUT_LAST)) begin
                            state        <= GAP;
                            rally_active <= 1'b0;
                            cnt          <= GAP_LOAD;
`endif
                        end else begin
`ifdef RALLY_TIMEOUT_EN
                            if (ball_valid) begin
                                frame_cnt <= frame_cnt + 12'd1;
                            end
`endif
                            if (hit_p1 && !hit_p2) begin
                                last_hitter <= P1;
                            end else if (hit_p2 && !hit_p1) begin
                                last_hitter <= P2;
                            end
                        end
                    end
                    AWARD: begin
                        if (cnt == '0) begin
                            add_p1 <= 1'b0;
                            add_p2 <= 1'b0;
                            cnt    <= GAP_LOAD;
                            state  <= GAP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            state <= WAIT_SERVE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    GAME_OVER: begin
                    end
                    default: begin
                        state <= WAIT_SERVE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rally_judge.sv
// Self-checking bench for rally_judge: directed scenarios plus random play
// against a queue-based model of the award schedule.
module tb_rally_judge;

    localparam int A_CYC = 4;
    localparam int G_CYC = 4;
`ifdef RALLY_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        serve_btn  = 1'b0;
    logic        ball_valid = 1'b0;
    logic [11:0] ball_x     = '0;
    logic [11:0] ball_y     = '0;
    logic        hit_p1     = 1'b0;
    logic        hit_p2     = 1'b0;
    logic        serve_start;
    logic        server;
    logic        rally_active;

    rally_judge_if score ();

    always #5 clk = ~clk;

    rally_judge #(
        .AWARD_CYCLES(A_CYC),
        .GAP_CYCLES(G_CYC)
`ifdef RALLY_TIMEOUT_EN
        ,
        .TIMEOUT_FRAMES(TB_TIMEOUT)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .serve_btn(serve_btn),
        .ball_valid(ball_valid),
        .ball_x(ball_x),
        .ball_y(ball_y),
        .hit_p1(hit_p1),
        .hit_p2(hit_p2),
        .score(score),
        .serve_start(serve_start),
        .server(server),
        .rally_active(rally_active)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: what the game looks like, not how the RTL encodes it.
    bit       m_over, m_rally, m_busy, m_server, m_hitter, m_prev_btn;
    int       m_frames;
    bit [1:0] plan[$];            // upcoming {p1_add, p2_add} per cycle
    bit       e_p1, e_p2, e_start, e_active, e_server;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check("p1_add", score.player1_add_score, e_p1);
        check("p2_add", score.player2_add_score, e_p2);
        check("serve_start", serve_start, e_start);
        check("rally_active", rally_active, e_active);
        check("server", server, e_server);
        check("add_exclusive", score.player1_add_score & score.player2_add_score, 0);
    endtask

    function automatic void model_reset();
        m_over = 0; m_rally = 0; m_busy = 0; m_server = 0; m_hitter = 0;
        m_prev_btn = 0; m_frames = 0;
        plan.delete();
        e_p1 = 0; e_p2 = 0; e_start = 0; e_active = 0; e_server = 0;
    endfunction

    // Schedule a finished rally: given line pattern for 'high' cycles, then gap.
    function automatic void schedule(input bit [1:0] line, input int high);
        m_rally = 0; e_active = 0; m_busy = 1;
        repeat (high) plan.push_back(line);
        repeat (G_CYC) plan.push_back(2'b00);
        {e_p1, e_p2} = plan.pop_front();
    endfunction

    function automatic void model_step();
        bit rise;
        bit out_b, land, decided, winner;
        rise       = serve_btn && !m_prev_btn;
        m_prev_btn = serve_btn;
        e_start    = 0;
        if (score.player1_win || score.player2_win) begin
            m_over = 1; m_rally = 0; m_busy = 0; plan.delete();
            e_p1 = 0; e_p2 = 0; e_active = 0; e_server = 0; m_server = 0;
            return;
        end
        if (m_over) return;
        if (m_busy) begin
            if (plan.size() == 0) begin
                m_busy = 0;
                e_p1 = 0; e_p2 = 0;
            end else begin
                {e_p1, e_p2} = plan.pop_front();
            end
        end else if (m_rally) begin
            decided = 0; winner = 0;
            if (ball_valid) begin
                out_b = (ball_x < 40) || (ball_x > 600);
                land  = (ball_y >= 440);
                if (out_b) begin
                    winner = !m_hitter; decided = 1;
                end else if (land) begin
                    winner = (ball_x < 320); decided = 1;
                end
            end
            if (decided) begin
                m_server = winner; e_server = winner;
                schedule(winner ? 2'b01 : 2'b10, A_CYC);
            end else begin
`ifdef RALLY_TIMEOUT_EN
                if (ball_valid) begin
                    m_frames++;
                    if (m_frames == TB_TIMEOUT) begin
                        schedule(2'b00, 0);
                        return;
                    end
                end
`endif
                if (hit_p1 && !hit_p2) m_hitter = 0;
                else if (hit_p2 && !hit_p1) m_hitter = 1;
            end
        end else if (rise) begin
            e_start = 1; e_active = 1; m_rally = 1;
            m_hitter = m_server; m_frames = 0;
        end
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
        ball_valid = 0; hit_p1 = 0; hit_p2 = 0;
        compare_all();
    endtask

    task automatic do_reset();
        score.player1_win = 0; score.player2_win = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic press_serve();
        serve_btn = 0; tick();
        serve_btn = 1; tick();
        serve_btn = 0;
    endtask

    task automatic sample(input int x, input int y);
        ball_valid = 1; ball_x = 12'(x); ball_y = 12'(y);
        tick();
    endtask

    task automatic drain();
        repeat (A_CYC + G_CYC + 1) tick();
    endtask

    function automatic logic [11:0] pick_x();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 6))
                0: return 12'd39;
                1: return 12'd40;
                2: return 12'd319;
                3: return 12'd320;
                4: return 12'd321;
                5: return 12'd600;
                default: return 12'd601;
            endcase
        end
        return 12'($urandom_range(0, 700));
    endfunction

    initial begin
        score.player1_win = 0;
        score.player2_win = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1;

        // Landing on player1's half: player2 scores, 4 high then gap.
        press_serve();
        check("s1_serve_start", serve_start, 1);
        sample(100, 450);
        check("s1_p2_rise", score.player2_add_score, 1);
        repeat (A_CYC - 1) tick();
        check("s1_p2_last_high", score.player2_add_score, 1);
        tick();
        check("s1_p2_dropped", score.player2_add_score, 0);
        repeat (G_CYC) tick();
        check("s1_server", server, 1);

        // Out of bounds after player2's hit: player1 scores.
        do_reset();
        press_serve();
        hit_p2 = 1; tick();
        sample(620, 200);
        check("s2_p1_add", score.player1_add_score, 1);
        check("s2_server", server, 0);
        drain();

        // Landing exactly on the net column with a simultaneous hit.
        press_serve();
        ball_valid = 1; ball_x = 12'd320; ball_y = 12'd450; hit_p1 = 1;
        tick();
        check("s3_p1_add", score.player1_add_score, 1);
        drain();

        // Win during the second award cycle aborts and locks out.
        press_serve();
        sample(500, 460);
        tick();
        check("s4_award_cycle2", score.player1_add_score, 1);
        score.player1_win = 1;
        tick();
        check("s4_add_dropped", score.player1_add_score, 0);
        score.player1_win = 0;
        repeat (3) press_serve();
        check("s4_no_serve", serve_start, 0);

        // Asynchronous reset in the middle of an award.
        do_reset();
        press_serve();
        sample(100, 450);
        tick();
        check("s5_mid_award", score.player2_add_score, 1);
        do_reset();
        check("s5_server_cleared", server, 0);
        serve_btn = 1; tick();
        check("s5_serve_after_reset", serve_start, 1);
        serve_btn = 0;
        sample(300, 460);
        drain();

`ifdef RALLY_TIMEOUT_EN
        // Ten airborne in-bounds frames end the rally as a let.
        do_reset();
        press_serve();
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            sample(200 + i, 100);
            tick();
        end
        check("s6_let_no_add", score.player1_add_score | score.player2_add_score, 0);
        check("s6_let_server", server, 0);
        drain();
        press_serve();
        check("s6_serve_again", serve_start, 1);
`endif

        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 5) == 0) serve_btn = ~serve_btn;
                ball_valid = ($urandom_range(0, 5) == 0);
                ball_x     = pick_x();
                ball_y     = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(430, 479))
                                                         : 12'($urandom_range(0, 439));
                hit_p1     = ($urandom_range(0, 4) == 0);
                hit_p2     = ($urandom_range(0, 4) == 0);
                score.player1_win = ($urandom_range(0, 1499) == 0);
                score.player2_win = ($urandom_range(0, 1499) == 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rally_judge.md
Name: rally_judge

Overview:
- Producer side of the point-award interface: decides the end of each rally and drives player1_add_score / player2_add_score into the score controller.
- Watches the per-frame shuttlecock position and the player hit strobes, and detects landing or out-of-bounds.
- Sequences the award handshake: level held, then both lines low for a guaranteed gap.
- Tracks the serving player and stops issuing points once either win flag comes back.

Parameters:
- NET_X, 12'd320, x coordinate of the net; ball_x < NET_X is player1's half.
- GROUND_Y, 12'd440, landing threshold; ball_y >= GROUND_Y means the shuttle has landed.
- COURT_LEFT, 12'd40, inclusive left in-bounds limit.
- COURT_RIGHT, 12'd600, inclusive right in-bounds limit.
- AWARD_CYCLES, 4, cycles an add_score line is held high (min 1).
- GAP_CYCLES, 4, cycles both add_score lines are held low after an award (min 1).
- TIMEOUT_FRAMES, 1800, frame limit for the optional timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- serve_btn  in  1  debounced serve request, level
- ball_valid  in  1  one-cycle strobe; ball_x/ball_y are valid this cycle (once per frame)
- ball_x  in  12  shuttle x
- ball_y  in  12  shuttle y
- hit_p1  in  1  one-cycle strobe, player1 struck the shuttle
- hit_p2  in  1  one-cycle strobe, player2 struck the shuttle
- player1_win  in  1  from score controller
- player2_win  in  1  from score controller
- player1_add_score  out  1  award to player1
- player2_add_score  out  1  award to player2
- serve_start  out  1  one-cycle pulse; ball launcher starts a serve
- server  out  1  0 = player1 serves, 1 = player2 serves
- rally_active  out  1  high in RALLY

Behaviour:
Reset values (asynchronous on rst_n low):
- All outputs 0; server = 0; last_hitter = 0; state = WAIT_SERVE; counters 0.

States and transitions (all registered):
- WAIT_SERVE: on serve_btn rising edge (internally registered edge detect), pulse serve_start for 1 cycle and set last_hitter = server. Next state RALLY.
- RALLY: rally_active = 1. Ball samples are evaluated only when ball_valid = 1:
  - Out of bounds (ball_x < COURT_LEFT or ball_x > COURT_RIGHT): winner = !last_hitter.
  - Landed in bounds (ball_y >= GROUND_Y): winner = player2 if ball_x < NET_X, else player1. ball_x == NET_X counts as player2's half.
  - Either condition → AWARD.
  - Otherwise, hit_p1 / hit_p2 update last_hitter. If both hit strobes are high in the same cycle, keep the current last_hitter.
- AWARD:
  - Assert exactly one add line, the one selected by winner, for AWARD_CYCLES cycles. The line rises the cycle after the RALLY decision.
  - Set server = winner.
  - Next state GAP.
- GAP: both add lines low for GAP_CYCLES cycles, then WAIT_SERVE.
- GAME_OVER: all outputs 0; terminal until reset.

Priority and boundary rules:
- player1_win or player2_win high in any state → GAME_OVER next cycle. This takes priority over every transition, and an in-progress AWARD is cut short. The score controller has already counted that point on the rising edge.
- Landing/out and a hit strobe in the same cycle: the landing decision wins, the hit is ignored.
- Out and landed in the same sample: the out-of-bounds rule applies.
- serve_btn held high through GAP does not auto-serve; a fresh rising edge is required in WAIT_SERVE.
- ball_valid samples outside RALLY are ignored.
- Invariants: player1_add_score and player2_add_score are never high together. Each point produces exactly one rising edge followed by at least GAP_CYCLES low on both lines. This guarantees the controller's "both low" re-arm condition.

Optional Feature:
Macro RALLY_TIMEOUT_EN.
- Defined: a 12-bit frame counter counts ball_valid strobes in RALLY and clears on entry to RALLY. When it reaches TIMEOUT_FRAMES, the rally is a let: no add line is asserted, server is unchanged, and the FSM goes to GAP.
- Undefined: no counter, and a rally may last indefinitely.

Decomposition:
- Into main_package:
  - judge_state_t enum {WAIT_SERVE, RALLY, AWARD, GAP, GAME_OVER}
  - player_t typedef (1 bit, P1 = 0, P2 = 1)
  - court constants (NET_X, GROUND_Y, COURT_LEFT, COURT_RIGHT), shared with the physics and render blocks
- No sub-module: the hold/gap counter is one shared down-counter inside the block.

Test Plan:
- Landing on player1's half: reset, serve_btn rise, ball_valid with ball_x = 100, ball_y = 450 → player2_add_score high exactly 4 cycles starting 1 cycle later, then both low 4 cycles, server = 1, state WAIT_SERVE.
- Out of bounds: serve by player1, hit_p2 pulse, then sample ball_x = 620, ball_y = 200 → player1_add_score (last hitter p2 faulted), server = 0.
- Simultaneous events: landing sample with ball_x = 320 and hit_p1 in the same cycle → hit ignored, player1_add_score asserted (x == NET_X counts as player2's half).
- Win abort: assert player1_win during the second AWARD cycle → add line drops next cycle, all outputs stay 0, further serve_btn ignored until rst_n low.
- Async reset mid-AWARD: drive rst_n low between clock edges → outputs 0 immediately, server = 0; after release the first serve_btn rise yields serve_start.
- With RALLY_TIMEOUT_EN, TIMEOUT_FRAMES = 10: serve, then 10 ball_valid samples in bounds and airborne → no add line, server unchanged, WAIT_SERVE after 4-cycle gap.
